// File: rtl/adc_sched_pkg.sv
// Shared types and widths for the ADC conversion scheduler.
package adc_sched_pkg;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;

  typedef enum logic [2:0] {
    IDLE,
    PWRUP,
    CONV,
    WAIT_EOC,
    WAIT_RD,
    SPACE
  } adc_sched_state_t;

  typedef struct packed {
    logic              vld;
    logic [DATA_W-1:0] data;
  } adc_sample_t;

endpackage

// File: rtl/adc_period_timer.sv
// Free-running sample-period counter; restart re-zeroes it, term marks the last count.
module adc_period_timer
  import adc_sched_pkg::*;
#(
  parameter int PERIOD = 200,
  parameter int W      = CNT_W
) (
  input  logic clk_100M,
  input  logic Reset,
  input  logic restart,
  output logic term
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk_100M) begin
    if (!Reset)                          cnt <= '0;
    else if (restart || term)            cnt <= '0;
    else                                 cnt <= cnt + 1'b1;
  end

  assign term = (cnt == W'(PERIOD - 1));

endmodule

// File: rtl/adc_conv_scheduler.sv
// ADC sequencer: power-up, periodic CONVST, EOC/RD wait, capture into a valid/ready register.
// Optional averaging of 2**AVG_LOG2 captures is built when ADC_AVG_EN is defined.
module adc_conv_scheduler
  import adc_sched_pkg::*;
#(
  parameter int PWRUP_CYC      = 1000,
  parameter int CONVST_LOW_CYC = 4,
  parameter int SAMPLE_PERIOD  = 200,
  parameter int EOC_TIMEOUT    = 150,
  parameter int AVG_LOG2       = 2
) (
  input  logic              clk_100M,
  input  logic              Reset,
  input  logic              enable,
  input  logic              clear_err,
  input  logic              EOC_18,
  input  logic              RD_18,
  input  logic [DATA_W-1:0] db_in,
  output logic              CONVST_in,
  output logic              PD_in,
  output logic [DATA_W-1:0] sample_data,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              busy,
  output logic              timeout_err,
  output logic [7:0]        overrun_cnt
);

  adc_sched_state_t state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             cnt_clr, tmo_hit, rd_q, term, restart;
  logic             convst_nxt, pd_nxt, tmo, cap_raw, out_free, drop;
  adc_sample_t      cap;

  adc_period_timer #(.PERIOD(SAMPLE_PERIOD), .W(CNT_W)) u_timer (
    .clk_100M (clk_100M),
    .Reset    (Reset),
    .restart  (restart),
    .term     (term)
  );

  // Timeout window spans WAIT_EOC and WAIT_RD, so the counter is not cleared between them.
  assign tmo_hit = (cnt >= CNT_W'(EOC_TIMEOUT - 1));
  assign cnt_clr = (state_nxt != state) && (state_nxt != WAIT_RD);

  always_comb begin
    state_nxt  = state;
    convst_nxt = 1'b1;
    pd_nxt     = PD_in;
    restart    = 1'b0;
    tmo        = 1'b0;
    cap_raw    = 1'b0;
    case (state)
      IDLE: begin
        pd_nxt = 1'b0;
        if (enable) begin
          state_nxt = PWRUP;
          pd_nxt    = 1'b1;
        end
      end
      PWRUP: if (cnt == CNT_W'(PWRUP_CYC - 1)) begin
        state_nxt  = CONV;
        convst_nxt = 1'b0;
        restart    = 1'b1;
      end
      CONV: begin
        if (cnt == CNT_W'(CONVST_LOW_CYC - 1)) state_nxt  = WAIT_EOC;
        else                                   convst_nxt = 1'b0;
      end
      WAIT_EOC: begin
        if (!EOC_18) state_nxt = WAIT_RD;
        else if (tmo_hit) begin
          tmo       = 1'b1;
          state_nxt = SPACE;
        end
      end
      WAIT_RD: begin
        if (!rd_q && RD_18) begin
          cap_raw   = 1'b1;
          state_nxt = SPACE;
        end else if (tmo_hit) begin
          tmo       = 1'b1;
          state_nxt = SPACE;
        end
      end
      SPACE: if (term) begin
        if (enable) begin
          state_nxt  = CONV;
          convst_nxt = 1'b0;
          restart    = 1'b1;
        end else begin
          state_nxt = IDLE;
          pd_nxt    = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_100M) begin
    if (!Reset) begin
      state     <= IDLE;
      cnt       <= '0;
      CONVST_in <= 1'b1;
      PD_in     <= 1'b0;
      busy      <= 1'b0;
      rd_q      <= 1'b1;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_clr ? '0 : cnt + 1'b1;
      CONVST_in <= convst_nxt;
      PD_in     <= pd_nxt;
      busy      <= (state_nxt != IDLE);
      rd_q      <= RD_18;
    end
  end

`ifdef ADC_AVG_EN
  logic [DATA_W+AVG_LOG2-1:0] acc, sum;
  logic [AVG_LOG2-1:0]        grp;

  assign sum = acc + {{AVG_LOG2{1'b0}}, db_in};

  always_ff @(posedge clk_100M) begin
    if (!Reset || !enable) begin
      acc <= '0;
      grp <= '0;
    end else if (cap_raw) begin
      acc <= (&grp) ? '0 : sum;
      grp <= grp + 1'b1;
    end
  end

  always_comb begin
    cap.vld  = cap_raw && enable && (&grp);
    cap.data = sum[AVG_LOG2 +: DATA_W];
  end
`else
  always_comb begin
    cap.vld  = cap_raw;
    cap.data = db_in;
  end
`endif

  assign out_free = !sample_valid || sample_ready;
  assign drop     = cap.vld && !out_free;

  // Set beats clear on the same cycle for both error indications.
  always_ff @(posedge clk_100M) begin
    if (!Reset) begin
      sample_valid <= 1'b0;
      sample_data  <= '0;
      timeout_err  <= 1'b0;
      overrun_cnt  <= '0;
    end else begin
      if (cap.vld && out_free) begin
        sample_valid <= 1'b1;
        sample_data  <= cap.data;
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
      if (tmo)            timeout_err <= 1'b1;
      else if (clear_err) timeout_err <= 1'b0;
      if (clear_err)                        overrun_cnt <= drop ? 8'd1 : 8'd0;
      else if (drop && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
    end
  end

endmodule
